// File: rtl/noc_inject_port.sv
// noc_inject_port: injection port between one PE result stream and its local
// mesh router. Buffers payload words in a small FIFO and serialises each
// packet as one header flit {dest, src, len} followed by len+1 payload flits.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   src_id              this PE's mesh index (static after reset)
//   cmd_valid/cmd_ready packet command handshake (cmd_dest, cmd_len = words-1)
//   pe_data/pe_valid    payload word offer; pe_ready = FIFO not full
//   net_data/net_valid  flit towards the router; net_ready = router accepts
//   busy                packet in progress
//   pkt_count           packets completed since reset (wrapping)
module noc_inject_port #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  src_id,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [5:0]  cmd_dest,
   input  logic [3:0]  cmd_len,
   input  logic [15:0] pe_data,
   input  logic        pe_valid,
   output logic        pe_ready,
   output logic [15:0] net_data,
   output logic        net_valid,
   input  logic        net_ready,
   output logic        busy,
   output logic [15:0] pkt_count
);

   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OCC_W  = $clog2(DEPTH + 1);
   localparam int unsigned FLIT_W = 16;
   localparam int unsigned CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      BODY = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [5:0]         dest_q;
   logic [3:0]         len_q;
   logic [3:0]         beat_q;
   logic [FLIT_W-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [OCC_W-1:0]   occ_q;
   logic [CNT_W-1:0]   pkt_count_q;
   logic [CNT_W-1:0]   pkt_count_d;
   logic               fifo_empty;
   logic               push;
   logic               pop;
   logic               last_beat;

   // FIFO status and handshake qualifiers
   assign fifo_empty = (occ_q == '0);
   assign pe_ready   = (occ_q < OCC_W'(DEPTH));
   assign push       = pe_valid & pe_ready;
   assign pop        = (state_q == BODY) & ~fifo_empty & net_ready;
   assign last_beat  = pop & (beat_q == len_q);
   assign pkt_count  = pkt_count_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cmd_valid) state_d = HDR;
         HDR:     if (net_ready) state_d = BODY;
         BODY:    if (last_beat) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode; header flit is {dest, src, len}
   always_comb begin
      cmd_ready = 1'b0;
      net_valid = 1'b0;
      net_data  = '0;
      busy      = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
         end
         HDR: begin
            net_valid = 1'b1;
            net_data  = {dest_q, src_id, len_q};
            busy      = 1'b1;
         end
         BODY: begin
            net_valid = ~fifo_empty;
            net_data  = mem_q[rd_ptr_q];
            busy      = 1'b1;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

   // Command latch and beat counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dest_q <= '0;
         len_q  <= '0;
         beat_q <= '0;
      end else begin
         if (state_q == IDLE && cmd_valid) begin
            dest_q <= cmd_dest;
            len_q  <= cmd_len;
         end
         if (state_q == HDR && net_ready) begin
            beat_q <= '0;
         end else if (pop) begin
            beat_q <= beat_q + 4'(1);
         end
      end
   end

   // Completed-packet counter, wraps naturally at 16 bits
   always_comb begin
      pkt_count_d = pkt_count_q + CNT_W'(last_beat);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_count_q <= '0;
      end else begin
         pkt_count_q <= pkt_count_d;
      end
   end

   // Payload FIFO: circular pointers plus occupancy counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= pe_data;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   occ_q <= occ_q + OCC_W'(1);
            2'b01:   occ_q <= occ_q - OCC_W'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

endmodule

// File: tb/tb_noc_inject_port.sv
// Testbench for noc_inject_port: directed scenarios plus a randomized phase,
// checked by a monitor holding a packet-level model (command/header queue,
// payload word queue, in-flight flag, packet counter).
module tb_noc_inject_port;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  src_id;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [5:0]  cmd_dest;
   logic [3:0]  cmd_len;
   logic [15:0] pe_data;
   logic        pe_valid;
   logic        pe_ready;
   logic [15:0] net_data;
   logic        net_valid;
   logic        net_ready = 1'b0;
   logic        busy;
   logic [15:0] pkt_count;

   int          n_tests = 0;
   int          n_fail  = 0;

   int          ready_mode = 0;     // 0 always ready, 1 random, 2 manual
   logic        ready_manual = 1'b0;
   logic        wrap_req = 1'b0;

   // model state owned by the monitor
   logic [15:0] word_q [$];
   logic        in_flight = 1'b0;
   logic        hdr_pending = 1'b0;
   logic [15:0] cur_hdr = '0;
   int          remaining = 0;
   logic [15:0] model_pkts = '0;
   int unsigned flit_cnt = 0;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data = '0;
   logic        exp_valid;
   logic        push_ok;
   logic        idle_now;

   noc_inject_port #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .src_id    (src_id),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_dest  (cmd_dest),
      .cmd_len   (cmd_len),
      .pe_data   (pe_data),
      .pe_valid  (pe_valid),
      .pe_ready  (pe_ready),
      .net_data  (net_data),
      .net_valid (net_valid),
      .net_ready (net_ready),
      .busy      (busy),
      .pkt_count (pkt_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // router back-pressure driver
   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0:       net_ready = 1'b1;
         1:       net_ready = 1'($urandom_range(0, 1));
         default: net_ready = ready_manual;
      endcase
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_net_valid", 32'(net_valid), 32'd0);
         check("rst_net_data",  32'(net_data),  32'd0);
         check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
         check("rst_pe_ready",  32'(pe_ready),  32'd1);
         check("rst_busy",      32'(busy),      32'd0);
         check("rst_pkt_count", 32'(pkt_count), 32'd0);
         word_q.delete();
         in_flight   = 1'b0;
         hdr_pending = 1'b0;
         remaining   = 0;
         model_pkts  = '0;
         prev_stall  = 1'b0;
      end else begin
         exp_valid = in_flight && (hdr_pending || word_q.size() > 0);
         check("net_valid", 32'(net_valid), 32'(exp_valid));
         check("busy",      32'(busy),      32'(in_flight));
         check("cmd_ready", 32'(cmd_ready), 32'(!in_flight));
         check("pe_ready",  32'(pe_ready),  32'(word_q.size() < DEPTH));
         check("pkt_count", 32'(pkt_count), 32'(model_pkts));
         if (prev_stall) begin
            check("hold_valid", 32'(net_valid), 32'd1);
            check("hold_data",  32'(net_data),  32'(prev_data));
         end
         prev_stall = net_valid && !net_ready;
         prev_data  = net_data;

         idle_now = !in_flight;
         push_ok  = pe_valid && (word_q.size() < DEPTH);
         if (net_valid && net_ready) begin
            flit_cnt++;
            if (!in_flight) begin
               fail_now("flit_while_idle");
            end else if (hdr_pending) begin
               check("header", 32'(net_data), 32'(cur_hdr));
               hdr_pending = 1'b0;
            end else if (word_q.size() == 0) begin
               fail_now("flit_without_word");
            end else begin
               check("payload", 32'(net_data), 32'(word_q.pop_front()));
               remaining--;
               if (remaining == 0) begin
                  in_flight  = 1'b0;
                  model_pkts = model_pkts + 16'd1;
               end
            end
         end
         if (push_ok) word_q.push_back(pe_data);
         if (cmd_valid && idle_now) begin
            in_flight   = 1'b1;
            hdr_pending = 1'b1;
            cur_hdr     = {cmd_dest, src_id, cmd_len};
            remaining   = int'(cmd_len) + 1;
         end
         if (wrap_req) model_pkts = 16'hFFFF;
      end
   end

   task automatic send_cmd(input logic [5:0] dest, input logic [3:0] len);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      cmd_dest  = dest;
      cmd_len   = len;
      cmd_valid = 1'b1;
      while (!acc && n < 2000) begin
         @(negedge clk);
         acc = cmd_ready;
         @(posedge clk);
         #1;
         n++;
      end
      cmd_valid = 1'b0;
      if (!acc) fail_now("cmd_accept_timeout");
   endtask

   task automatic push_word(input logic [15:0] w);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      pe_data  = w;
      pe_valid = 1'b1;
      while (!acc && n < 2000) begin
         @(negedge clk);
         acc = pe_ready;
         @(posedge clk);
         #1;
         n++;
      end
      pe_valid = 1'b0;
      if (!acc) fail_now("push_timeout");
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (busy) fail_now("idle_timeout");
      @(posedge clk);
      #1;
   endtask

   // watchdog
   initial begin
      #600000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int          c;
      logic        done;
      int unsigned f0;
      int          lens [25];

      rst_n     = 1'b0;
      src_id    = 6'd5;
      cmd_valid = 1'b0;
      cmd_dest  = '0;
      cmd_len   = '0;
      pe_valid  = 1'b0;
      pe_data   = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // single packet, always ready
      push_word(16'h1111);
      push_word(16'h2222);
      push_word(16'h3333);
      send_cmd(6'h2A, 4'd2);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t1_consecutive", 32'(net_valid && net_ready), 32'd1);
         if (k == 0) check("t1_header", 32'(net_data), 32'hA852);
      end
      @(negedge clk);
      check("t1_busy_after", 32'(busy), 32'd0);
      check("t1_pkt_count", 32'(pkt_count), 32'd1);
      @(posedge clk);
      #1;

      // back-pressure: ready alternates 0/1 starting low at the header
      ready_mode   = 2;
      ready_manual = 1'b0;
      push_word(16'h1111);
      push_word(16'h2222);
      push_word(16'h3333);
      send_cmd(6'h2A, 4'd2);
      c    = 0;
      done = 1'b0;
      while (!done && c < 40) begin
         ready_manual = (c % 2 == 1);
         @(negedge clk);
         if (!busy) done = 1'b1;
         else begin
            @(posedge clk);
            #1;
            c++;
         end
      end
      check("t2_cycles", 32'(c), 32'd8);
      @(posedge clk);
      #1;
      ready_mode = 0;

      // FIFO full, then starvation with a 16-word packet
      for (int i = 0; i < 4; i++) push_word(16'hA000 + 16'(i));
      @(negedge clk);
      check("t3_full", 32'(pe_ready), 32'd0);
      @(posedge clk);
      #1;
      pe_data  = 16'hDEAD;
      pe_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("t3_no_fifth", 32'(pe_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      pe_valid = 1'b0;
      f0 = flit_cnt;
      fork
         send_cmd(6'h11, 4'd15);
         begin
            for (int i = 0; i < 12; i++) begin
               repeat (2) @(posedge clk);
               #1;
               push_word(16'hB000 + 16'(i));
            end
         end
      join
      wait_idle();
      check("t3_flits", 32'(flit_cnt - f0), 32'd17);

      // push and pop together while full
      for (int i = 0; i < 4; i++) push_word(16'hC000 + 16'(i));
      ready_mode   = 2;
      ready_manual = 1'b0;
      send_cmd(6'h07, 4'd4);
      ready_manual = 1'b1;
      @(posedge clk);
      #1;
      ready_manual = 1'b0;
      pe_data      = 16'h5555;
      pe_valid     = 1'b1;
      @(negedge clk);
      check("t4_full_body", 32'(pe_ready), 32'd0);
      @(posedge clk);
      #1;
      ready_manual = 1'b1;
      @(negedge clk);
      check("t4_full_pop", 32'(pe_ready), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("t4_after_pop", 32'(pe_ready), 32'd1);
      @(posedge clk);
      #1;
      pe_valid   = 1'b0;
      ready_mode = 0;
      wait_idle();

      // reset during body beat 1
      for (int i = 0; i < 4; i++) push_word(16'hD000 + 16'(i));
      send_cmd(6'h3F, 4'd3);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t5_net_valid", 32'(net_valid), 32'd0);
      check("t5_cmd_ready", 32'(cmd_ready), 32'd1);
      check("t5_pkt_count", 32'(pkt_count), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      push_word(16'hBEEF);
      send_cmd(6'h01, 4'd0);
      wait_idle();
      check("t5_after_pkt", 32'(pkt_count), 32'd1);
      check("t5_fifo_empty", 32'(pe_ready), 32'd1);

      // counter wrap: preload 0xFFFF through the next-value net
      force dut.pkt_count_d = 16'hFFFF;
      wrap_req = 1'b1;
      @(posedge clk);
      #1;
      release dut.pkt_count_d;
      wrap_req = 1'b0;
      @(negedge clk);
      check("t6_preload", 32'(pkt_count), 32'hFFFF);
      @(posedge clk);
      #1;
      push_word(16'h0F0F);
      send_cmd(6'h02, 4'd0);
      wait_idle();
      check("t6_wrap", 32'(pkt_count), 32'h0000);

      // randomized traffic
      ready_mode = 1;
      foreach (lens[i]) lens[i] = int'($urandom_range(0, 15));
      fork
         begin
            for (int p = 0; p < 25; p++) begin
               repeat ($urandom_range(0, 3)) begin
                  @(posedge clk);
                  #1;
               end
               send_cmd(6'($urandom_range(0, 63)), 4'(lens[p]));
            end
         end
         begin
            for (int p = 0; p < 25; p++) begin
               for (int w = 0; w <= lens[p]; w++) begin
                  repeat ($urandom_range(0, 2)) begin
                     @(posedge clk);
                     #1;
                  end
                  push_word(16'($urandom));
               end
            end
         end
      join
      wait_idle();
      check("t7_pkt_count", 32'(pkt_count), 32'd25);
      check("t7_fifo_empty", 32'(pe_ready), 32'd1);
      ready_mode = 0;
      repeat (2) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
